// File: rtl/usb_packet_rx_if.sv
// Bit-level receive bus between the NRZI/de-stuff front end and the USB packet receiver.
interface usb_packet_rx_if #(
    parameter int unsigned MAX_BYTES = 64
);
    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 3);

    logic             bit_in;
    logic             bit_valid;
    logic             bus_sop;
    logic             bus_eop;
    logic [6:0]       dev_addr;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic [3:0]       pid;
    logic             pid_valid;
    logic [6:0]       addr;
    logic [3:0]       endp;
    logic [10:0]      frame;
    logic             addr_match;
    logic [CNT_W-1:0] byte_count;
    logic             pkt_done;
    logic             pkt_good;
    logic             err_pid;
    logic             err_crc;
    logic             err_len;
    logic             err_align;

    modport master (
        output bit_in, bit_valid, bus_sop, bus_eop, dev_addr,
        input  byte_out, byte_valid, pid, pid_valid, addr, endp, frame, addr_match,
               byte_count, pkt_done, pkt_good, err_pid, err_crc, err_len, err_align
    );

    modport slave (
        input  bit_in, bit_valid, bus_sop, bus_eop, dev_addr,
        output byte_out, byte_valid, pid, pid_valid, addr, endp, frame, addr_match,
               byte_count, pkt_done, pkt_good, err_pid, err_crc, err_len, err_align
    );
endinterface

// File: rtl/usb_packet_rx.sv
// USB packet receiver: PID decode, token field capture, CRC5/CRC16 check and
// DATA byte delivery through a two-byte holdback that swallows the CRC16 bytes.
module usb_packet_rx #(
    parameter int unsigned MAX_BYTES   = 64,
    parameter int unsigned ADDR_FILTER = 1
) (
    input logic            clk48,
    input logic            reset,
    usb_packet_rx_if.slave bus
);
    localparam int unsigned      CNT_W   = $clog2(MAX_BYTES + 3);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BYTES + 3);

    typedef enum logic [1:0] {S_IDLE, S_PID, S_PAYLOAD, S_DONE} state_t;

    state_t      state, state_nx;
    logic [6:0]  pid_sr;
    logic [2:0]  pid_bits;
    logic [6:0]  byte_sr;
    logic [2:0]  bit_idx;
    logic [7:0]  hold0, hold1;
    logic [4:0]  crc5;
    logic [15:0] crc16;

    logic        take_c, pid_bit_c, pid_last_c, pid_ok_c, pay_bit_c, byte_end_c;
    logic        frame_bit_c, emit_c, eop_c;
    logic [7:0]  pid_byte_c, new_byte_c;
    logic [4:0]  crc5_nx_c;
    logic [15:0] crc16_nx_c;
    logic        is_token_c, is_hs_c, is_data_c;
    logic        len_c, crc_c, align_c, match_c, good_c;

    assign bus.addr = bus.frame[6:0];
    assign bus.endp = bus.frame[10:7];

    always_ff @(posedge clk48) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.bus_sop) begin
            state_nx = S_PID;
        end else begin
            case (state)
                S_PID: begin
                    if (bus.bus_eop)                               state_nx = S_DONE;
                    else if (bus.bit_valid && pid_bits == 3'd7)    state_nx = S_PAYLOAD;
                end
                S_PAYLOAD: if (bus.bus_eop) state_nx = S_DONE;
                S_DONE:    state_nx = S_IDLE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    // Per-cycle strobes and end-of-packet verdict feeding the registered outputs.
    always_comb begin
        take_c      = bus.bit_valid && !bus.bus_eop && !bus.bus_sop &&
                      (state == S_PID || state == S_PAYLOAD);
        pid_bit_c   = take_c && (state == S_PID);
        pid_last_c  = pid_bit_c && (pid_bits == 3'd7);
        pid_byte_c  = {bus.bit_in, pid_sr};
        pid_ok_c    = (pid_byte_c[3:0] == ~pid_byte_c[7:4]) && (pid_byte_c[3:0] != 4'h0);
        pay_bit_c   = take_c && (state == S_PAYLOAD);
        byte_end_c  = pay_bit_c && (bit_idx == 3'd7);
        new_byte_c  = {bus.bit_in, byte_sr};
        frame_bit_c = pay_bit_c && (bus.byte_count == '0 ||
                                    (bus.byte_count == CNT_ONE && bit_idx < 3'd3));
        eop_c       = bus.bus_eop && !bus.bus_sop && (state == S_PID || state == S_PAYLOAD);
        crc5_nx_c   = {crc5[3:0], 1'b0} ^ ((crc5[4] ^ bus.bit_in) ? 5'h05 : 5'h00);
        crc16_nx_c  = {crc16[14:0], 1'b0} ^ ((crc16[15] ^ bus.bit_in) ? 16'h8005 : 16'h0000);

        is_token_c = 1'b0;
        is_hs_c    = 1'b0;
        is_data_c  = 1'b0;
        case (bus.pid)
            4'h1, 4'h9, 4'h5, 4'hD: is_token_c = 1'b1;
            4'h2, 4'hA, 4'hE, 4'h6: is_hs_c    = 1'b1;
            4'h3, 4'hB, 4'h7, 4'hF: is_data_c  = 1'b1;
            default: ;
        endcase

        // Byte index n completing releases byte n-2 unless it lies past MAX_BYTES.
        emit_c = byte_end_c && is_data_c && bus.pid_valid &&
                 bus.byte_count >= CNT_TWO && bus.byte_count < CNT_MAX;

        len_c   = 1'b0;
        crc_c   = 1'b0;
        align_c = 1'b0;
        if (state == S_PID) begin
            len_c = 1'b1;
        end else if (is_token_c) begin
            len_c = !(bus.byte_count == CNT_TWO && bit_idx == 3'd0);
            crc_c = (crc5 != 5'h0C);
        end else if (is_hs_c) begin
            len_c = !(bus.byte_count == '0 && bit_idx == 3'd0);
        end else if (is_data_c) begin
            align_c = (bit_idx != 3'd0);
            len_c   = (bus.byte_count < CNT_TWO) || (bus.byte_count > CNT_MAX);
            crc_c   = (crc16 != 16'h800D);
        end else begin
            len_c = 1'b1;
        end

        match_c = (ADDR_FILTER == 0) || !is_token_c || (bus.pid == 4'h5) ||
                  (bus.frame[6:0] == bus.dev_addr);
        good_c  = bus.pid_valid && match_c && !len_c && !crc_c && !align_c;
    end

    always_ff @(posedge clk48) begin
        if (reset || bus.bus_sop) begin
            pid_sr         <= '0;
            pid_bits       <= '0;
            byte_sr        <= '0;
            bit_idx        <= '0;
            hold0          <= '0;
            hold1          <= '0;
            crc5           <= reset ? 5'h00 : 5'h1F;
            crc16          <= reset ? 16'h0000 : 16'hFFFF;
            bus.byte_out   <= '0;
            bus.byte_valid <= 1'b0;
            bus.pid        <= '0;
            bus.pid_valid  <= 1'b0;
            bus.frame      <= '0;
            bus.addr_match <= 1'b0;
            bus.byte_count <= '0;
            bus.pkt_done   <= 1'b0;
            bus.pkt_good   <= 1'b0;
            bus.err_pid    <= 1'b0;
            bus.err_crc    <= 1'b0;
            bus.err_len    <= 1'b0;
            bus.err_align  <= 1'b0;
        end else begin
            bus.byte_valid <= 1'b0;
            bus.pkt_done   <= 1'b0;
            bus.pkt_good   <= 1'b0;
            if (pid_bit_c) begin
                pid_sr   <= pid_byte_c[7:1];
                pid_bits <= pid_bits + 3'd1;
            end
            if (pid_last_c) begin
                bus.pid       <= pid_byte_c[3:0];
                bus.pid_valid <= pid_ok_c;
            end
            if (pay_bit_c) begin
                crc5    <= crc5_nx_c;
                crc16   <= crc16_nx_c;
                byte_sr <= new_byte_c[7:1];
                bit_idx <= bit_idx + 3'd1;
            end
            if (frame_bit_c) bus.frame <= {bus.bit_in, bus.frame[10:1]};
            if (byte_end_c) begin
                hold1 <= hold0;
                hold0 <= new_byte_c;
                if (bus.byte_count != CNT_SAT) bus.byte_count <= bus.byte_count + CNT_ONE;
            end
            if (emit_c) begin
                bus.byte_out   <= hold1;
                bus.byte_valid <= 1'b1;
            end
            if (eop_c) begin
                bus.pkt_done   <= 1'b1;
                bus.pkt_good   <= good_c;
                bus.addr_match <= match_c;
                bus.err_pid    <= !bus.pid_valid;
                bus.err_crc    <= crc_c;
                bus.err_len    <= len_c;
                bus.err_align  <= align_c;
            end
        end
    end
endmodule

// File: tb/tb_usb_packet_rx.sv
// Directed bench for usb_packet_rx: default build plus a MAX_BYTES=4 build fed the same bit stream.
`timescale 1ns/1ps
module tb_usb_packet_rx;
    logic clk48 = 1'b0;
    logic reset;
    always #5 clk48 = ~clk48;

    usb_packet_rx_if #(.MAX_BYTES(64)) u_if ();
    usb_packet_rx_if #(.MAX_BYTES(4))  if4 ();

    assign if4.bit_in    = u_if.bit_in;
    assign if4.bit_valid = u_if.bit_valid;
    assign if4.bus_sop   = u_if.bus_sop;
    assign if4.bus_eop   = u_if.bus_eop;
    assign if4.dev_addr  = u_if.dev_addr;

    usb_packet_rx #(.MAX_BYTES(64), .ADDR_FILTER(1)) dut  (.clk48(clk48), .reset(reset), .bus(u_if.slave));
    usb_packet_rx #(.MAX_BYTES(4),  .ADDR_FILTER(1)) dut4 (.clk48(clk48), .reset(reset), .bus(if4.slave));

    int vectors = 0;
    int miscompares = 0;
    int nb = 0, nb4 = 0, ndone = 0;
    logic [7:0] got  [0:255];
    logic [7:0] got4 [0:255];
    logic [7:0] dbuf [0:15];

    // Byte and packet monitors sample mid-cycle.
    always @(negedge clk48) begin
        if (u_if.byte_valid) begin got[nb[7:0]] <= u_if.byte_out; nb <= nb + 1; end
        if (if4.byte_valid)  begin got4[nb4[7:0]] <= if4.byte_out; nb4 <= nb4 + 1; end
        if (u_if.pkt_done)   ndone <= ndone + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] crc5_field(input logic [10:0] v);
        logic [4:0] c;
        logic fb;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ v[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return ~c;
    endfunction

    function automatic logic [15:0] crc16_field(input logic [7:0] d [0:15], input int n);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ d[k][i];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        return ~c;
    endfunction

    task automatic step();
        @(posedge clk48); #1;
    endtask

    task automatic send_bit(input logic b);
        u_if.bit_in = b; u_if.bit_valid = 1'b1; step(); u_if.bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic pulse_sop();
        u_if.bus_sop = 1'b1; step(); u_if.bus_sop = 1'b0;
    endtask

    task automatic pulse_eop();
        u_if.bus_eop = 1'b1; step(); u_if.bus_eop = 1'b0;
    endtask

    task automatic send_token(input logic [3:0] p, input logic [10:0] v, input bit flip);
        logic [4:0] c;
        c = crc5_field(v);
        if (flip) c[0] = ~c[0];
        pulse_sop();
        send_byte({~p, p});
        for (int i = 0; i < 11; i++) send_bit(v[i]);
        for (int i = 4; i >= 0; i--) send_bit(c[i]);
        pulse_eop();
    endtask

    task automatic send_crc16(input int n, input bit flip);
        logic [15:0] c;
        c = crc16_field(dbuf, n);
        if (flip) c[3] = ~c[3];
        for (int i = 15; i >= 0; i--) send_bit(c[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
        vectors++; if (u_if.pkt_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %0b expected 0", u_if.pkt_done); end
        vectors++; if ({u_if.pid_valid, u_if.pid} !== 5'h00) begin miscompares++; $display("FAIL rst_pid: got %0h expected 0", {u_if.pid_valid, u_if.pid}); end
        vectors++; if (u_if.byte_count !== 7'd0) begin miscompares++; $display("FAIL rst_count: got %0d expected 0", u_if.byte_count); end
        vectors++; if ({u_if.err_pid, u_if.err_crc, u_if.err_len, u_if.err_align, u_if.addr_match, u_if.byte_valid} !== 6'b0) begin miscompares++; $display("FAIL rst_flags: got %b expected 000000", {u_if.err_pid, u_if.err_crc, u_if.err_len, u_if.err_align, u_if.addr_match, u_if.byte_valid}); end
        vectors++; if (u_if.frame !== 11'h000) begin miscompares++; $display("FAIL rst_frame: got %0h expected 0", u_if.frame); end
    endtask

    task automatic test_ack();
        int b;
        b = nb;
        pulse_sop(); send_byte(8'hD2); pulse_eop();
        vectors++; if ({u_if.pkt_done, u_if.pkt_good} !== 2'b11) begin miscompares++; $display("FAIL ack_done_good: got %b expected 11", {u_if.pkt_done, u_if.pkt_good}); end
        vectors++; if (u_if.pid !== 4'h2) begin miscompares++; $display("FAIL ack_pid: got %0h expected 2", u_if.pid); end
        vectors++; if (u_if.byte_count !== 7'd0) begin miscompares++; $display("FAIL ack_count: got %0d expected 0", u_if.byte_count); end
        vectors++; if ({u_if.err_pid, u_if.err_crc, u_if.err_len, u_if.err_align} !== 4'b0) begin miscompares++; $display("FAIL ack_errs: got %b expected 0000", {u_if.err_pid, u_if.err_crc, u_if.err_len, u_if.err_align}); end
        vectors++; if (nb - b !== 0) begin miscompares++; $display("FAIL ack_bytes: got %0d expected 0", nb - b); end
        step();
        vectors++; if ({u_if.pkt_done, u_if.pkt_good, u_if.pid_valid} !== 3'b001) begin miscompares++; $display("FAIL ack_after: got %b expected 001", {u_if.pkt_done, u_if.pkt_good, u_if.pid_valid}); end
    endtask

    task automatic test_token();
        u_if.dev_addr = 7'h3A;
        send_token(4'h1, 11'h0BA, 1'b0);
        vectors++; if ({u_if.pkt_done, u_if.pkt_good, u_if.addr_match} !== 3'b111) begin miscompares++; $display("FAIL out_good: got %b expected 111", {u_if.pkt_done, u_if.pkt_good, u_if.addr_match}); end
        vectors++; if ({u_if.addr, u_if.endp} !== {7'h3A, 4'h1}) begin miscompares++; $display("FAIL out_fields: got %0h expected %0h", {u_if.addr, u_if.endp}, {7'h3A, 4'h1}); end
        step();
        u_if.dev_addr = 7'h05;
        send_token(4'h1, 11'h0BA, 1'b0);
        vectors++; if ({u_if.pkt_good, u_if.addr_match} !== 2'b00) begin miscompares++; $display("FAIL out_mismatch: got %b expected 00", {u_if.pkt_good, u_if.addr_match}); end
        vectors++; if ({u_if.err_crc, u_if.err_len} !== 2'b00) begin miscompares++; $display("FAIL out_mismatch_errs: got %b expected 00", {u_if.err_crc, u_if.err_len}); end
        step();
        send_token(4'h5, 11'h123, 1'b0);
        vectors++; if ({u_if.pkt_good, u_if.addr_match, u_if.frame} !== {2'b11, 11'h123}) begin miscompares++; $display("FAIL sof: got %0h expected %0h", {u_if.pkt_good, u_if.addr_match, u_if.frame}, {2'b11, 11'h123}); end
        step();
        u_if.dev_addr = 7'h3A;
        send_token(4'h1, 11'h0BA, 1'b1);
        vectors++; if ({u_if.pkt_good, u_if.err_crc} !== 2'b01) begin miscompares++; $display("FAIL out_badcrc: got %b expected 01", {u_if.pkt_good, u_if.err_crc}); end
        step();
    endtask

    task automatic test_data();
        int b;
        b = nb;
        dbuf[0] = 8'h01; dbuf[1] = 8'h02; dbuf[2] = 8'h03;
        pulse_sop(); send_byte(8'hC3); send_byte(8'h01); send_byte(8'h02);
        vectors++; if (u_if.byte_valid !== 1'b0) begin miscompares++; $display("FAIL data_early: got %0b expected 0", u_if.byte_valid); end
        send_byte(8'h03);
        vectors++; if ({u_if.byte_valid, u_if.byte_out} !== 9'h101) begin miscompares++; $display("FAIL data_first_byte: got %0h expected 101", {u_if.byte_valid, u_if.byte_out}); end
        send_crc16(3, 1'b0); pulse_eop();
        vectors++; if (nb - b !== 3) begin miscompares++; $display("FAIL data_nbytes: got %0d expected 3", nb - b); end
        vectors++; if ({got[b[7:0]], got[8'(b + 1)], got[8'(b + 2)]} !== 24'h010203) begin miscompares++; $display("FAIL data_bytes: got %0h expected 010203", {got[b[7:0]], got[8'(b + 1)], got[8'(b + 2)]}); end
        vectors++; if ({u_if.pkt_good, u_if.byte_count} !== {1'b1, 7'd5}) begin miscompares++; $display("FAIL data_good_count: got %0h expected %0h", {u_if.pkt_good, u_if.byte_count}, {1'b1, 7'd5}); end
        step();
        pulse_sop(); send_byte(8'hC3); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_crc16(3, 1'b1); pulse_eop();
        vectors++; if ({u_if.pkt_good, u_if.err_crc, u_if.err_len} !== 3'b010) begin miscompares++; $display("FAIL data_badcrc: got %b expected 010", {u_if.pkt_good, u_if.err_crc, u_if.err_len}); end
        step();
    endtask

    task automatic test_max_bytes();
        int b, b4;
        b = nb; b4 = nb4;
        for (int i = 0; i < 6; i++) dbuf[i] = 8'(8'h10 + i);
        pulse_sop(); send_byte(8'h4B);
        for (int i = 0; i < 6; i++) send_byte(dbuf[i]);
        send_crc16(6, 1'b0); pulse_eop();
        vectors++; if (nb4 - b4 !== 4) begin miscompares++; $display("FAIL max4_nbytes: got %0d expected 4", nb4 - b4); end
        vectors++; if ({got4[b4[7:0]], got4[8'(b4 + 1)], got4[8'(b4 + 2)], got4[8'(b4 + 3)]} !== 32'h10111213) begin miscompares++; $display("FAIL max4_bytes: got %0h expected 10111213", {got4[b4[7:0]], got4[8'(b4 + 1)], got4[8'(b4 + 2)], got4[8'(b4 + 3)]}); end
        vectors++; if ({if4.pkt_done, if4.pkt_good, if4.err_len, if4.byte_count} !== {3'b101, 3'd7}) begin miscompares++; $display("FAIL max4_verdict: got %b expected 101111", {if4.pkt_done, if4.pkt_good, if4.err_len, if4.byte_count}); end
        vectors++; if ({nb - b, 32'(u_if.pkt_good), 32'(u_if.byte_count)} !== {32'd6, 32'd1, 32'd8}) begin miscompares++; $display("FAIL max64_verdict: got %0d/%0b/%0d expected 6/1/8", nb - b, u_if.pkt_good, u_if.byte_count); end
        step();
    endtask

    task automatic test_align();
        int b;
        b = nb;
        pulse_sop(); send_byte(8'hC3); send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        pulse_eop();
        vectors++; if ({u_if.pkt_done, u_if.err_align, u_if.pkt_good} !== 3'b110) begin miscompares++; $display("FAIL align_flags: got %b expected 110", {u_if.pkt_done, u_if.err_align, u_if.pkt_good}); end
        vectors++; if (u_if.byte_count !== 7'd1) begin miscompares++; $display("FAIL align_count: got %0d expected 1", u_if.byte_count); end
        vectors++; if (nb - b !== 0) begin miscompares++; $display("FAIL align_bytes: got %0d expected 0", nb - b); end
        step();
    endtask

    task automatic test_restart();
        int d;
        d = ndone;
        pulse_sop(); send_byte(8'hC3); send_byte(8'h55); send_bit(1'b1);
        pulse_sop(); send_byte(8'hD2); pulse_eop();
        vectors++; if ({u_if.pkt_done, u_if.pkt_good, u_if.pid} !== 6'b11_0010) begin miscompares++; $display("FAIL restart_ack: got %b expected 110010", {u_if.pkt_done, u_if.pkt_good, u_if.pid}); end
        step();
        vectors++; if (ndone - d !== 1) begin miscompares++; $display("FAIL restart_ndone: got %0d expected 1", ndone - d); end
    endtask

    task automatic test_errors();
        pulse_sop(); for (int i = 0; i < 4; i++) send_bit(1'b0);
        pulse_eop();
        vectors++; if ({u_if.pkt_done, u_if.pkt_good, u_if.err_len} !== 3'b101) begin miscompares++; $display("FAIL eop_in_pid: got %b expected 101", {u_if.pkt_done, u_if.pkt_good, u_if.err_len}); end
        step();
        pulse_sop(); send_byte(8'hD2); send_byte(8'h00); pulse_eop();
        vectors++; if ({u_if.pkt_good, u_if.err_len} !== 2'b01) begin miscompares++; $display("FAIL ack_long: got %b expected 01", {u_if.pkt_good, u_if.err_len}); end
        step();
        pulse_sop(); send_byte(8'hD3); pulse_eop();
        vectors++; if ({u_if.pid_valid, u_if.err_pid, u_if.pkt_good} !== 3'b010) begin miscompares++; $display("FAIL bad_pid: got %b expected 010", {u_if.pid_valid, u_if.err_pid, u_if.pkt_good}); end
        step();
        pulse_sop(); send_byte(8'hD2);
        u_if.bit_in = 1'b1; u_if.bit_valid = 1'b1; u_if.bus_eop = 1'b1; step();
        u_if.bit_valid = 1'b0; u_if.bus_eop = 1'b0;
        vectors++; if ({u_if.pkt_done, u_if.pkt_good, u_if.err_len} !== 3'b110) begin miscompares++; $display("FAIL eop_bit_priority: got %b expected 110", {u_if.pkt_done, u_if.pkt_good, u_if.err_len}); end
        step();
        send_byte(8'hFF); pulse_eop();
        vectors++; if ({u_if.pkt_done, u_if.byte_count} !== 8'h00) begin miscompares++; $display("FAIL idle_ignore: got %0h expected 0", {u_if.pkt_done, u_if.byte_count}); end
    endtask

    task automatic test_reset_mid();
        int b, d;
        pulse_sop(); send_byte(8'hC3); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        vectors++; if ({u_if.pid_valid, u_if.pid, u_if.byte_count, u_if.byte_valid, u_if.pkt_done} !== 14'h0) begin miscompares++; $display("FAIL midreset_outputs: got %0h expected 0", {u_if.pid_valid, u_if.pid, u_if.byte_count, u_if.byte_valid, u_if.pkt_done}); end
        b = nb; d = ndone;
        for (int i = 0; i < 20; i++) send_bit(i[1]);
        pulse_eop(); step();
        vectors++; if ({nb - b, ndone - d} !== 64'd0) begin miscompares++; $display("FAIL midreset_idle: got bytes %0d dones %0d expected 0 0", nb - b, ndone - d); end
    endtask

    initial begin
        reset = 1'b1;
        u_if.bit_in = 1'b0; u_if.bit_valid = 1'b0; u_if.bus_sop = 1'b0; u_if.bus_eop = 1'b0;
        u_if.dev_addr = 7'h3A;
        test_reset();
        test_ack();
        test_token();
        test_data();
        test_max_bytes();
        test_align();
        test_restart();
        test_errors();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
